// File: rtl/proc_alu_pkg.sv
// Shared opcode encodings, FSM state and operation-class helpers for proc_alu_mc.
// PROC_ALU_MC_DIV_EN decides whether opcodes 12..15 decode as divide operations.
package proc_alu_pkg;

  localparam logic [31:0] OP_ADD   = 32'd0;
  localparam logic [31:0] OP_SUB   = 32'd1;
  localparam logic [31:0] OP_AND   = 32'd2;
  localparam logic [31:0] OP_OR    = 32'd3;
  localparam logic [31:0] OP_XOR   = 32'd4;
  localparam logic [31:0] OP_SLL   = 32'd5;
  localparam logic [31:0] OP_SRL   = 32'd6;
  localparam logic [31:0] OP_SRA   = 32'd7;
  localparam logic [31:0] OP_SLT   = 32'd8;
  localparam logic [31:0] OP_SLTU  = 32'd9;
  localparam logic [31:0] OP_MUL   = 32'd10;
  localparam logic [31:0] OP_MULHU = 32'd11;
  localparam logic [31:0] OP_DIV   = 32'd12;
  localparam logic [31:0] OP_DIVU  = 32'd13;
  localparam logic [31:0] OP_REM   = 32'd14;
  localparam logic [31:0] OP_REMU  = 32'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_SIMPLE  = 2'd0,
    CLS_MUL     = 2'd1,
    CLS_DIV     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

  typedef enum logic [2:0] {
    MDU_MUL   = 3'd0,
    MDU_MULHU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_REM   = 3'd4,
    MDU_REMU  = 3'd5
  } mdu_op_t;

  function automatic op_class_t op_class(input logic [31:0] op);
    op_class_t cls;
    if (op <= OP_SLTU) begin
      cls = CLS_SIMPLE;
    end else if (op <= OP_MULHU) begin
      cls = CLS_MUL;
`ifdef PROC_ALU_MC_DIV_EN
    end else if (op <= OP_REMU) begin
      cls = CLS_DIV;
`endif
    end else begin
      cls = CLS_ILLEGAL;
    end
    return cls;
  endfunction

  function automatic mdu_op_t mdu_op_of(input logic [31:0] op);
    mdu_op_t m;
    case (op)
      OP_MULHU: m = MDU_MULHU;
      OP_DIV:   m = MDU_DIV;
      OP_DIVU:  m = MDU_DIVU;
      OP_REM:   m = MDU_REM;
      OP_REMU:  m = MDU_REMU;
      default:  m = MDU_MUL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/proc_alu_mdu_iter.sv
// Iterative multiply (shift-add) and restoring-divide datapath, one bit per cycle.
// The divider exists only when PROC_ALU_MC_DIV_EN is defined.
module proc_alu_mdu_iter
  import proc_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  mdu_op_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  logic            active;
  logic [CW-1:0]   cnt;
  mdu_op_t         op_q;
  logic [W-1:0]    mcand;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  prod_nxt;
  logic [W:0]      sum;

  // last is combinational so the final step result can be captured on the same edge
  assign last = active & (cnt == CW'(W - 1));

  // Step sequencing: W steps after start, counter wraps back to zero on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= {CW{1'b0}};
      op_q   <= MDU_MUL;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= {CW{1'b0}};
      op_q   <= op;
    end else if (active) begin
      cnt    <= cnt + CW'(1);
      active <= ~last;
    end else begin
      active <= 1'b0;
    end
  end

  // Shift-add: multiplier sits in the low half and drains out as the product fills in
  always_comb begin
    sum      = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    prod_nxt = {sum, prod[W-1:1]};
  end

  // Multiplier registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= {W{1'b0}};
      prod  <= {(2*W){1'b0}};
    end else if (start) begin
      mcand <= a;
      prod  <= {{W{1'b0}}, b};
    end else if (active) begin
      prod  <= prod_nxt;
    end else begin
      prod  <= prod;
    end
  end

`ifdef PROC_ALU_MC_DIV_EN
  logic [W-1:0] divisor;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic [W-1:0] quo_nxt;
  logic [W-1:0] rem_nxt;
  logic [W-1:0] a_hold;
  logic [W:0]   shifted;
  logic [W:0]   diff;
  logic         neg_q;
  logic         neg_r;
  logic         div_zero;
  logic         sgn_a;
  logic         sgn_b;

  assign sgn_a = ((op == MDU_DIV) | (op == MDU_REM)) & a[W-1];
  assign sgn_b = ((op == MDU_DIV) | (op == MDU_REM)) & b[W-1];

  // Restoring step on magnitudes; a zero divisor naturally yields all-ones quotient
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

  // Divider registers; signs are stripped on entry and reapplied to the final result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor  <= {W{1'b0}};
      quo      <= {W{1'b0}};
      rem      <= {W{1'b0}};
      a_hold   <= {W{1'b0}};
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      divisor  <= sgn_b ? -b : b;
      quo      <= sgn_a ? -a : a;
      rem      <= {W{1'b0}};
      a_hold   <= a;
      neg_q    <= sgn_a ^ sgn_b;
      neg_r    <= sgn_a;
      div_zero <= (b == {W{1'b0}});
    end else if (active) begin
      quo      <= quo_nxt;
      rem      <= rem_nxt;
    end else begin
      quo      <= quo;
    end
  end
`endif

  // Final result formed from the step being taken now, valid while last is high
  always_comb begin
    result = {W{1'b0}};
    case (op_q)
      MDU_MUL:   result = prod_nxt[W-1:0];
      MDU_MULHU: result = prod_nxt[2*W-1:W];
`ifdef PROC_ALU_MC_DIV_EN
      MDU_DIV, MDU_DIVU: result = div_zero ? {W{1'b1}} : (neg_q ? -quo_nxt : quo_nxt);
      MDU_REM, MDU_REMU: result = div_zero ? a_hold : (neg_r ? -rem_nxt : rem_nxt);
`endif
      default:   result = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/proc_alu_mc.sv
// Multi-cycle ALU: single-cycle simple ops, iterative MUL/DIV via proc_alu_mdu_iter.
// Define PROC_ALU_MC_DIV_EN to enable opcodes 12..15; otherwise they are illegal.
module proc_alu_mc
  import proc_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ISA_DPTH   = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [$clog2(ISA_DPTH)-1:0] i_opcode,
  input  logic [DATA_WIDTH-1:0]       i_data_a,
  input  logic [DATA_WIDTH-1:0]       i_data_b,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_WIDTH-1:0]       o_data_alu,
  output logic                        o_err
);

  localparam int SHW = $clog2(DATA_WIDTH);

  state_t                state;
  logic                  accept;
  logic [31:0]           op_ext;
  op_class_t             cls;
  mdu_op_t               mdu_op;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] simple_res;
  logic [DATA_WIDTH-1:0] mdu_result;
  logic                  mdu_start;
  logic                  mdu_last;

  assign op_ext    = 32'(i_opcode);
  assign cls       = op_class(op_ext);
  assign mdu_op    = mdu_op_of(op_ext);
  assign shamt     = i_data_b[SHW-1:0];
  assign o_ready   = (state == ST_IDLE) | ((state == ST_DONE) & i_ready);
  assign accept    = i_valid & o_ready;
  assign mdu_start = accept & ((cls == CLS_MUL) | (cls == CLS_DIV));

  // Single-cycle operations, computed from the live inputs and captured on acceptance
  always_comb begin
    simple_res = {DATA_WIDTH{1'b0}};
    case (op_ext)
      OP_ADD:  simple_res = i_data_a + i_data_b;
      OP_SUB:  simple_res = i_data_a - i_data_b;
      OP_AND:  simple_res = i_data_a & i_data_b;
      OP_OR:   simple_res = i_data_a | i_data_b;
      OP_XOR:  simple_res = i_data_a ^ i_data_b;
      OP_SLL:  simple_res = i_data_a << shamt;
      OP_SRL:  simple_res = i_data_a >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(i_data_a) >>> shamt);
      OP_SLT:  simple_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
      OP_SLTU: simple_res = {{(DATA_WIDTH-1){1'b0}}, (i_data_a < i_data_b)};
      default: simple_res = {DATA_WIDTH{1'b0}};
    endcase
  end

  proc_alu_mdu_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mdu (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (mdu_start),
    .op     (mdu_op),
    .a      (i_data_a),
    .b      (i_data_b),
    .last   (mdu_last),
    .result (mdu_result)
  );

  // Control FSM with registered result outputs; a DONE result is held until consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_data_alu <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            case (cls)
              CLS_SIMPLE: begin
                state      <= ST_DONE;
                o_valid    <= 1'b1;
                o_err      <= 1'b0;
                o_data_alu <= simple_res;
              end
              CLS_MUL, CLS_DIV: begin
                state      <= ST_BUSY;
                o_valid    <= 1'b0;
                o_err      <= 1'b0;
              end
              default: begin
                state      <= ST_DONE;
                o_valid    <= 1'b1;
                o_err      <= 1'b1;
                o_data_alu <= {DATA_WIDTH{1'b0}};
              end
            endcase
          end else if ((state == ST_DONE) && !i_ready) begin
            state <= ST_DONE;
          end else begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mdu_last) begin
            state      <= ST_DONE;
            o_valid    <= 1'b1;
            o_err      <= 1'b0;
            o_data_alu <= mdu_result;
          end else begin
            state <= ST_BUSY;
          end
        end
        default: begin
          state      <= ST_IDLE;
          o_valid    <= 1'b0;
          o_err      <= 1'b0;
          o_data_alu <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_alu_mc.sv
// Scoreboard bench for proc_alu_mc: requests push model results, a monitor pops on output.
// Expectations for opcodes 12..15 follow PROC_ALU_MC_DIV_EN.
module tb_proc_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [5:0]  i_opcode = 6'd0;
  logic [31:0] i_data_a = 32'd0;
  logic [31:0] i_data_b = 32'd0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_data_alu;
  logic        o_err;

  proc_alu_mc #(.DATA_WIDTH(32), .ISA_DPTH(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_data_a(i_data_a), .i_data_b(i_data_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_data_alu(o_data_alu), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t new_e;
  logic [32:0] new_m;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_acc = 0;
  bit   presented = 1'b0;
  bit   rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_long(input int op);
`ifdef PROC_ALU_MC_DIV_EN
    return (op >= 10) && (op <= 15);
`else
    return (op == 10) || (op == 11);
`endif
  endfunction

  // Reference: {err, result} from plain arithmetic on the operation's definition
  function automatic logic [32:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    int          sh;
    logic [32:0] r;
    sh = int'(b[4:0]);
    p  = {32'd0, a} * {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {1'b1, 32'd0};
    case (op)
      0:  r = {1'b0, a + b};
      1:  r = {1'b0, a - b};
      2:  r = {1'b0, a & b};
      3:  r = {1'b0, a | b};
      4:  r = {1'b0, a ^ b};
      5:  r = {1'b0, a << sh};
      6:  r = {1'b0, a >> sh};
      7:  r = {1'b0, 32'($signed(a) >>> sh)};
      8:  r = {1'b0, (sa < sb) ? 32'd1 : 32'd0};
      9:  r = {1'b0, (a < b) ? 32'd1 : 32'd0};
      10: r = {1'b0, p[31:0]};
      11: r = {1'b0, p[63:32]};
`ifdef PROC_ALU_MC_DIV_EN
      12: if (b == 32'd0) r = {1'b0, 32'hFFFF_FFFF}; else r = {1'b0, 32'(sa / sb)};
      13: if (b == 32'd0) r = {1'b0, 32'hFFFF_FFFF}; else r = {1'b0, a / b};
      14: if (b == 32'd0) r = {1'b0, a}; else r = {1'b0, 32'(sa % sb)};
      15: if (b == 32'd0) r = {1'b0, a}; else r = {1'b0, a % b};
`endif
      default: r = {1'b1, 32'd0};
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance watcher: each handshake pushes its expected response
  always @(negedge clk) begin
    if (rst_n && i_valid && o_ready) begin
      new_m      = model(int'(i_opcode), i_data_a, i_data_b);
      new_e.data = new_m[31:0];
      new_e.err  = new_m[32];
      new_e.acc  = cyc + 1;
      new_e.lat  = is_long(int'(i_opcode)) ? 33 : 1;
      sbq.push_back(new_e);
      last_acc   = cyc + 1;
      n_vec++;
    end
  end

  // Output monitor: first presentation checks value and latency, later cycles check hold
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got o_data_alu 0x%0h with no request outstanding", o_data_alu);
      end else begin
        mon_e = sbq[0];
        if (!presented) begin
          chk("result", 64'(o_data_alu), 64'(mon_e.data));
          chk("err", 64'(o_err), 64'(mon_e.err));
          chk("latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
          presented = 1'b1;
        end else begin
          chk("hold_data", 64'(o_data_alu), 64'(mon_e.data));
          chk("hold_err", 64'(o_err), 64'(mon_e.err));
        end
        chk("ready_in_done", 64'(o_ready), 64'(i_ready));
        if (i_ready) begin
          void'(sbq.pop_front());
          presented = 1'b0;
        end
      end
    end
  end

  // Random result back-pressure during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
    int n;
    i_valid  = 1'b1;
    i_opcode = 6'(op);
    i_data_a = a;
    i_data_b = b;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: o_ready 0 after %0d cycles, want 1", n);
    end
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_opcode = 6'($urandom);
    i_data_a = $urandom;
    i_data_b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          a0;
    int          op;
    logic [31:0] ra;
    logic [31:0] rb;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_data", 64'(o_data_alu), 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;

    issue(0, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(10, 32'h0001_0000, 32'h0001_0000);
    issue(11, 32'h0001_0000, 32'h0001_0000);
    issue(12, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(14, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(13, 32'h0000_0007, 32'h0000_0000);
    issue(15, 32'h0000_0007, 32'h0000_0000);
    issue(12, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(14, 32'hFFFF_FFF9, 32'h0000_0000);
    issue(7, 32'h8000_0000, 32'h0000_0024);
    issue(20, 32'h1234_5678, 32'h0000_0001);
    drain();

    // Result held for five cycles under back-pressure, then back-to-back SUBs
    i_ready = 1'b0;
    issue(0, 32'h0000_1234, 32'h0000_1111);
    repeat (5) @(posedge clk);
    #1 i_ready = 1'b1;
    issue(1, 32'h0000_0010, 32'h0000_0003);
    a0 = last_acc;
    issue(1, 32'h0000_0000, 32'h0000_0001);
    issue(1, 32'h8000_0000, 32'h0000_0001);
    issue(1, 32'h1234_5678, 32'h1234_5678);
    chk("b2b_rate", 64'(last_acc - a0), 64'd3);
    drain();

    // Reset asserted in the middle of a long operation
    issue(0, 32'h0000_0005, 32'h0000_0006);
`ifdef PROC_ALU_MC_DIV_EN
    issue(13, 32'hDEAD_BEEF, 32'h0000_0013);
`else
    issue(10, 32'hDEAD_BEEF, 32'h0000_0013);
`endif
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_valid", 64'(o_valid), 64'd0);
    chk("rst_busy_data", 64'(o_data_alu), 64'd0);
    chk("rst_busy_err", 64'(o_err), 64'd0);
    sbq.delete();
    presented = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_busy_rst", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    issue(0, 32'h0000_0100, 32'h0000_0023);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      issue(op, ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 i_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
